// File: rtl/dryer_pkg.sv
// Shared dryer definitions: heat level codes, arbiter state encoding and
// the default one-second tick divider for a 50 kHz clock.
package dryer_pkg;

    localparam logic [1:0] HEAT_OFF = 2'b00;
    localparam logic [1:0] HEAT_LO  = 2'b01;
    localparam logic [1:0] HEAT_MD  = 2'b10;
    localparam logic [1:0] HEAT_HI  = 2'b11;

    localparam int unsigned DEFAULT_TICK_DIV = 50000;

    typedef enum logic [1:0] {
        SHARE = 2'd0,
        A_PRI = 2'd1,
        B_PRI = 2'd2
    } arb_state_t;

    function automatic logic [2:0] min3(input logic [2:0] x, input logic [2:0] y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle tick on its last
// count; first tick TICK_DIV cycles after RESET.
module tick_prescaler
    import dryer_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic CLK,
    input  logic RESET,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/heater_power_arbiter.sv
// Splits a shared heater stage budget between dryer units A and B with
// rotating priority under contention. Define HEAT_STAGGER_EN for tick-paced ramp-up.
module heater_power_arbiter
    import dryer_pkg::*;
#(
    parameter int unsigned BUDGET   = 4,
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
    parameter int unsigned ROTATE_S = 900
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ_A,
    input  logic [1:0] REQ_B,
    input  logic       MTR_A,
    input  logic       MTR_B,
    output logic [1:0] HTR_A,
    output logic [1:0] HTR_B,
    output logic       CONTEND,
    output logic       PRIO
);

    localparam logic [2:0] BUD = 3'(BUDGET);
    localparam int unsigned RW = (ROTATE_S > 1) ? $clog2(ROTATE_S) : 1;
    localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_S - 1);

    logic          tick;
    arb_state_t    state, state_nxt;
    logic          rr;
    logic [RW-1:0] rot_cnt;
    logic [2:0]    eff_a, eff_b;
    logic [2:0]    tgt_a, tgt_b;
    logic [2:0]    dec_a, dec_b;
    logic [1:0]    new_a, new_b;
    logic          contention, rotate_due;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .tick  (tick)
    );

    assign eff_a      = MTR_A ? {1'b0, REQ_A} : 3'd0;
    assign eff_b      = MTR_B ? {1'b0, REQ_B} : 3'd0;
    assign contention = (eff_a + eff_b) > BUD;
    assign rotate_due = tick && (rot_cnt == ROT_LAST);

    // Contention clear outranks a rotation falling on the same tick.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SHARE: if (contention) state_nxt = rr ? B_PRI : A_PRI;
            A_PRI: begin
                if (!contention)     state_nxt = SHARE;
                else if (rotate_due) state_nxt = B_PRI;
            end
            B_PRI: begin
                if (!contention)     state_nxt = SHARE;
                else if (rotate_due) state_nxt = A_PRI;
            end
            default: state_nxt = SHARE;
        endcase
    end

    always_comb begin
        tgt_a = eff_a;
        tgt_b = eff_b;
        if (state == A_PRI) begin
            tgt_b = min3(eff_b, BUD - eff_a);
        end else if (state == B_PRI) begin
            tgt_a = min3(eff_a, BUD - eff_b);
        end

        // Decreases always land; increases are checked against post-decrease grants.
        dec_a = min3({1'b0, HTR_A}, tgt_a);
        dec_b = min3({1'b0, HTR_B}, tgt_b);
        new_a = dec_a[1:0];
        new_b = dec_b[1:0];
`ifdef HEAT_STAGGER_EN
        if (tick) begin
            if ((state == B_PRI) && (tgt_b > dec_b)) begin
                if ((dec_a + dec_b + 3'd1) <= BUD) new_b = dec_b[1:0] + 2'd1;
            end else if (tgt_a > dec_a) begin
                if ((dec_a + dec_b + 3'd1) <= BUD) new_a = dec_a[1:0] + 2'd1;
            end else if (tgt_b > dec_b) begin
                if ((dec_a + dec_b + 3'd1) <= BUD) new_b = dec_b[1:0] + 2'd1;
            end
        end
`else
        if ((tgt_a > dec_a) && ((tgt_a + dec_b) <= BUD)) begin
            new_a = tgt_a[1:0];
        end
        if ((tgt_b > dec_b) && (({1'b0, new_a} + tgt_b) <= BUD)) begin
            new_b = tgt_b[1:0];
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= SHARE;
            rr      <= 1'b0;
            rot_cnt <= '0;
            HTR_A   <= HEAT_OFF;
            HTR_B   <= HEAT_OFF;
            CONTEND <= 1'b0;
            PRIO    <= 1'b0;
        end else begin
            state   <= state_nxt;
            CONTEND <= contention;
            HTR_A   <= new_a;
            HTR_B   <= new_b;

            if (state == SHARE) begin
                if (contention) begin
                    rr      <= ~rr;
                    rot_cnt <= '0;
                end
            end else if (state_nxt != state) begin
                rot_cnt <= '0;
            end else if (tick) begin
                rot_cnt <= rot_cnt + 1'b1;
            end

            if (state_nxt == A_PRI) begin
                PRIO <= 1'b0;
            end else if (state_nxt == B_PRI) begin
                PRIO <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_heater_power_arbiter.sv
// Bench for heater_power_arbiter: steady-state vector table plus timed
// contention, rotation, motor-drop and reset sequences, both ramp modes.
module tb_heater_power_arbiter;

    localparam int unsigned TD  = 8;
    localparam int unsigned BUD = 4;
    localparam int unsigned ROT = 3;
`ifdef HEAT_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] REQ_A = 2'b00;
    logic [1:0] REQ_B = 2'b00;
    logic       MTR_A = 1'b0;
    logic       MTR_B = 1'b0;
    logic [1:0] HTR_A, HTR_B;
    logic       CONTEND, PRIO;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit run    = 1'b0;

    heater_power_arbiter #(.BUDGET(BUD), .TICK_DIV(TD), .ROTATE_S(ROT)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ_A   (REQ_A),
        .REQ_B   (REQ_B),
        .MTR_A   (MTR_A),
        .MTR_B   (MTR_B),
        .HTR_A   (HTR_A),
        .HTR_B   (HTR_B),
        .CONTEND (CONTEND),
        .PRIO    (PRIO)
    );

    always #10 CLK = ~CLK;

    // Cycles since the last reset edge; ticks land on edges where cyc % TD == 0.
    always @(posedge CLK) cyc <= RESET ? 0 : cyc + 1;

    always @(negedge CLK) begin
        if (run) begin
            checks++;
            if (({1'b0, HTR_A} + {1'b0, HTR_B}) > 3'(BUD)) begin
                errors++;
                $display("FAIL budget sum at cyc %0d: HTR_A=%0d HTR_B=%0d exceeds %0d", cyc, HTR_A, HTR_B, BUD);
            end
        end
    end

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [1:0] a;
        logic [1:0] b;
        logic       c;
        logic       p;
    } exp_t;

    typedef struct {
        logic       ma;
        logic [1:0] ra;
        logic       mb;
        logic [1:0] rb;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       ec;
    } vec_t;

    exp_t sb[$];

    task automatic cmp(input string name, input string field, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", name, field, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [3:0] mask, input logic [1:0] a,
                            input logic [1:0] b, input logic c, input logic p);
        exp_t e;
        e.name = name; e.mask = mask; e.a = a; e.b = b; e.c = c; e.p = p;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expectation queued at cyc %0d", cyc);
            return;
        end
        e = sb.pop_front();
        if (e.mask[3]) cmp(e.name, "HTR_A", {2'b00, HTR_A}, {2'b00, e.a});
        if (e.mask[2]) cmp(e.name, "HTR_B", {2'b00, HTR_B}, {2'b00, e.b});
        if (e.mask[1]) cmp(e.name, "CONTEND", {3'b000, CONTEND}, {3'b000, e.c});
        if (e.mask[0]) cmp(e.name, "PRIO", {3'b000, PRIO}, {3'b000, e.p});
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic to_tick();
        step();
        while ((cyc % TD) != 0) step();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        int   guard;

        tbl[0] = '{1'b0, 2'b11, 1'b0, 2'b11, 2'd0, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 2'b01, 1'b0, 2'b00, 2'd1, 2'd0, 1'b0};
        tbl[2] = '{1'b1, 2'b11, 1'b1, 2'b01, 2'd3, 2'd1, 1'b0};
        tbl[3] = '{1'b1, 2'b10, 1'b1, 2'b10, 2'd2, 2'd2, 1'b0};
        tbl[4] = '{1'b1, 2'b00, 1'b1, 2'b11, 2'd0, 2'd3, 1'b0};
        tbl[5] = '{1'b0, 2'b11, 1'b1, 2'b01, 2'd0, 2'd1, 1'b0};
        tbl[6] = '{1'b1, 2'b01, 1'b1, 2'b11, 2'd1, 2'd3, 1'b0};
        tbl[7] = '{1'b1, 2'b11, 1'b0, 2'b10, 2'd3, 2'd0, 1'b0};

        REQ_A = 2'b11; REQ_B = 2'b11;
        step();
        step();
        push_exp("reset", 4'b1111, 2'd0, 2'd0, 1'b0, 1'b0);
        check_out();
        RESET = 1'b0;
        run   = 1'b1;

        for (int i = 0; i < 8; i++) begin
            MTR_A = tbl[i].ma; REQ_A = tbl[i].ra;
            MTR_B = tbl[i].mb; REQ_B = tbl[i].rb;
            push_exp($sformatf("table[%0d]", i), 4'b1111, tbl[i].ea, tbl[i].eb, tbl[i].ec, 1'b0);
            repeat (64) step();
            check_out();
        end

        // Single-unit ramp from reset
        MTR_A = 1'b0; MTR_B = 1'b0; REQ_A = 2'b00; REQ_B = 2'b00;
        do_reset();
        MTR_A = 1'b1; REQ_A = 2'b11;
`ifdef HEAT_STAGGER_EN
        push_exp("pre-tick hold", 4'b1010, 2'd0, 2'd0, 1'b0, 1'b0);
        step();
        check_out();
        for (int k = 1; k <= 3; k++) begin
            push_exp($sformatf("stagger ramp %0d", k), 4'b1110, 2'(k), 2'd0, 1'b0, 1'b0);
            to_tick();
            check_out();
        end
`else
        push_exp("direct step", 4'b1110, 2'd3, 2'd0, 1'b0, 1'b0);
        step();
        check_out();
        to_tick();
`endif

        // Contention onset, capped grant, then rotation after ROT ticks
        MTR_B = 1'b1; REQ_B = 2'b11;
        push_exp("contend onset", 4'b1111, 2'd3, 2'd0, 1'b1, 1'b0);
        step();
        check_out();
        push_exp("B capped", 4'b1111, 2'd3, 2'd1, 1'b1, 1'b0);
        to_tick();
        check_out();
        to_tick();
        push_exp("rotate tick", 4'b1111, 2'd3, 2'd1, 1'b1, 1'b1);
        to_tick();
        check_out();
`ifdef HEAT_STAGGER_EN
        push_exp("loser drops", 4'b1111, 2'd1, 2'd1, 1'b1, 1'b1);
        step();
        check_out();
        push_exp("gainer ramp", 4'b1111, 2'd1, 2'd2, 1'b1, 1'b1);
        to_tick();
        check_out();
        MTR_B = 1'b0;
        push_exp("motor drop", 4'b1111, 2'd1, 2'd0, 1'b0, 1'b1);
        step();
        check_out();
        push_exp("A regain 1", 4'b1110, 2'd2, 2'd0, 1'b0, 1'b0);
        to_tick();
        check_out();
        push_exp("A regain 2", 4'b1110, 2'd3, 2'd0, 1'b0, 1'b0);
        to_tick();
        check_out();
`else
        push_exp("loser drops", 4'b1111, 2'd1, 2'd3, 1'b1, 1'b1);
        step();
        check_out();
        MTR_B = 1'b0;
        push_exp("motor drop", 4'b1111, 2'd3, 2'd0, 1'b0, 1'b1);
        step();
        check_out();
`endif

        // Round-robin hands the next contention to B, then reset mid-B_PRI
        MTR_B = 1'b1;
        push_exp("rr to B", 4'b1111, 2'd3, 2'd0, 1'b1, 1'b1);
        step();
        check_out();
        push_exp("B_PRI trims A", 4'b1111, 2'd1, STAG ? 2'd0 : 2'd3, 1'b1, 1'b1);
        step();
        check_out();
        RESET = 1'b1;
        push_exp("reset in B_PRI", 4'b1111, 2'd0, 2'd0, 1'b0, 1'b0);
        step();
        check_out();
        RESET = 1'b0;
        push_exp("post-reset A_PRI", 4'b1111, STAG ? 2'd0 : 2'd3, 2'd0, 1'b1, 1'b0);
        step();
        check_out();

        // Contention clears on the very tick that would rotate
        guard = 0;
        while ((cyc != ROT * TD - 1) && (guard < 200)) begin
            step();
            guard++;
        end
        cmp("rotate sync", "cyc", 4'(cyc % 16), 4'((ROT * TD - 1) % 16));
        MTR_B = 1'b0;
        push_exp("rotate vs clear", 4'b0111, 2'd0, 2'd0, 1'b0, 1'b0);
        step();
        check_out();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
